// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Purpose  : Producer-side register hazard tracker for a 5-stage MIPS
//            pipeline. Counts in-flight GPR writes from issue to retire,
//            split into all writes and long-latency (non-forwardable)
//            writes, and tells decode when to stall.
// Ports    : clk, rst (async, active-high)
//            issue_valid/issue_wen/issue_dest/issue_long  - write issued
//            retire_valid/retire_dest/retire_long         - WB write
//            flush                                        - clear all in-flight
//            de_raddr1/de_use1/de_raddr2/de_use2          - decode sources
//            de_dest/de_wen                               - decode destination
//            stall      - decode must hold (comb from state + de_*)
//            busy_vec   - reg r has at least one pending write
//            sb_err     - sticky protocol-error flag
//            stall_cnt  - stall-cycle counter (0 unless SB_STATS_EN)
// Config   : define SB_STATS_EN to build the 32-bit stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_wen,
    input  logic [4:0]      issue_dest,
    input  logic            issue_long,
    input  logic            retire_valid,
    input  logic [4:0]      retire_dest,
    input  logic            retire_long,
    input  logic            flush,
    input  logic [4:0]      de_raddr1,
    input  logic            de_use1,
    input  logic [4:0]      de_raddr2,
    input  logic            de_use2,
    input  logic [4:0]      de_dest,
    input  logic            de_wen,
    output logic            stall,
    output logic [NREG-1:0] busy_vec,
    output logic            sb_err,
    output logic [31:0]     stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // Per-register counters packed flat so decode can index them by address.
    logic [NREG*CNT_W-1:0] all_flat;
    logic [NREG*CNT_W-1:0] long_flat;
    logic [NREG-1:0]       err_vec;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_zero
            // Register 0 is hard-wired and never tracked.
            assign all_flat[r*CNT_W +: CNT_W]  = CNT_ZERO;
            assign long_flat[r*CNT_W +: CNT_W] = CNT_ZERO;
            assign busy_vec[r]                 = 1'b0;
            assign err_vec[r]                  = 1'b0;
        end else begin : g_track
            localparam logic [4:0] IDX = 5'(r);

            logic [CNT_W-1:0] cnt_all, cnt_long;
            logic [CNT_W-1:0] all_nxt, long_nxt;
            logic             inc_all, dec_all, inc_long, dec_long;
            logic             err_nxt;

            assign inc_all  = issue_valid & issue_wen & (issue_dest == IDX);
            assign dec_all  = retire_valid & (retire_dest == IDX);
            assign inc_long = inc_all & issue_long;
            assign dec_long = dec_all & retire_long;

            // Simultaneous issue and retire on this register cancel out, so
            // saturation is only checked on a net increment or decrement.
            always_comb begin
                all_nxt  = cnt_all;
                long_nxt = cnt_long;
                err_nxt  = 1'b0;
                if (inc_all && !dec_all) begin
                    if (cnt_all == CNT_MAX) err_nxt = 1'b1;
                    else                    all_nxt = cnt_all + CNT_ONE;
                end else if (dec_all && !inc_all) begin
                    if (cnt_all == CNT_ZERO) err_nxt = 1'b1;
                    else                     all_nxt = cnt_all - CNT_ONE;
                end
                if (inc_long && !dec_long) begin
                    if (cnt_long == CNT_MAX) err_nxt  = 1'b1;
                    else                     long_nxt = cnt_long + CNT_ONE;
                end else if (dec_long && !inc_long) begin
                    if (cnt_long == CNT_ZERO) err_nxt  = 1'b1;
                    else                      long_nxt = cnt_long - CNT_ONE;
                end
                if (long_nxt > all_nxt) err_nxt = 1'b1;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_all  <= CNT_ZERO;
                    cnt_long <= CNT_ZERO;
                end else if (flush) begin
                    cnt_all  <= CNT_ZERO;
                    cnt_long <= CNT_ZERO;
                end else begin
                    cnt_all  <= all_nxt;
                    cnt_long <= long_nxt;
                end
            end

            assign all_flat[r*CNT_W +: CNT_W]  = cnt_all;
            assign long_flat[r*CNT_W +: CNT_W] = cnt_long;
            assign busy_vec[r]                 = |cnt_all;
            // Events in a flush cycle are ignored, including their errors.
            assign err_vec[r]                  = err_nxt & ~flush;
        end
    end

    // Decode hazard lookup: registered state only, so a write issued this
    // cycle affects decode from the next cycle.
    logic [CNT_W-1:0] src1_long, src2_long, dst_all;
    logic             haz1, haz2, haz_full;

    assign src1_long = long_flat[de_raddr1*CNT_W +: CNT_W];
    assign src2_long = long_flat[de_raddr2*CNT_W +: CNT_W];
    assign dst_all   = all_flat[de_dest*CNT_W +: CNT_W];

    assign haz1     = de_use1 & (de_raddr1 != 5'd0) & (src1_long != CNT_ZERO);
    assign haz2     = de_use2 & (de_raddr2 != 5'd0) & (src2_long != CNT_ZERO);
    assign haz_full = de_wen  & (de_dest   != 5'd0) & (dst_all == CNT_MAX);
    assign stall    = haz1 | haz2 | haz_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sb_err <= 1'b0;
        else if (|err_vec) sb_err <= 1'b1;
    end

`ifdef SB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        stall_cnt <= 32'd0;
        else if (stall) stall_cnt <= stall_cnt + 32'd1;
    end
`else
    assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Purpose  : Directed, table-driven bench for reg_scoreboard. Each table row
//            is driven for one clock; outputs are sampled before the rising
//            edge, so expected busy/err reflect earlier rows and expected
//            stall reflects earlier state plus this row's decode inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wen, issue_long;
    logic [4:0]  issue_dest;
    logic        retire_valid, retire_long;
    logic [4:0]  retire_dest;
    logic        flush;
    logic [4:0]  de_raddr1, de_raddr2, de_dest;
    logic        de_use1, de_use2, de_wen;
    logic        stall;
    logic [31:0] busy_vec;
    logic        sb_err;
    logic [31:0] stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_sc  = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_dest(issue_dest), .issue_long(issue_long),
        .retire_valid(retire_valid), .retire_dest(retire_dest),
        .retire_long(retire_long), .flush(flush),
        .de_raddr1(de_raddr1), .de_use1(de_use1),
        .de_raddr2(de_raddr2), .de_use2(de_use2),
        .de_dest(de_dest), .de_wen(de_wen),
        .stall(stall), .busy_vec(busy_vec), .sb_err(sb_err),
        .stall_cnt(stall_cnt)
    );

    // -1 in iss/ret/a1/a2/dd means "inactive".
    typedef struct {
        int          rs;
        int          iss;
        int          il;
        int          ret;
        int          rl;
        int          fl;
        int          a1;
        int          a2;
        int          dd;
        logic        es;
        logic [31:0] eb;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int rs, int iss, int il, int ret, int rl, int fl,
                                int a1, int a2, int dd,
                                logic es, logic [31:0] eb, logic ee);
        vec_t v;
        v.rs = rs; v.iss = iss; v.il = il; v.ret = ret; v.rl = rl; v.fl = fl;
        v.a1 = a1; v.a2 = a2; v.dd = dd; v.es = es; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic drive(vec_t v);
        rst          = (v.rs != 0);
        issue_valid  = (v.iss >= 0);
        issue_wen    = (v.iss >= 0);
        issue_dest   = (v.iss >= 0) ? 5'(v.iss) : 5'd0;
        issue_long   = (v.il != 0);
        retire_valid = (v.ret >= 0);
        retire_dest  = (v.ret >= 0) ? 5'(v.ret) : 5'd0;
        retire_long  = (v.rl != 0);
        flush        = (v.fl != 0);
        de_use1      = (v.a1 >= 0);
        de_raddr1    = (v.a1 >= 0) ? 5'(v.a1) : 5'd0;
        de_use2      = (v.a2 >= 0);
        de_raddr2    = (v.a2 >= 0) ? 5'(v.a2) : 5'd0;
        de_wen       = (v.dd >= 0);
        de_dest      = (v.dd >= 0) ? 5'(v.dd) : 5'd0;
    endtask

    function automatic logic [31:0] exp_sc();
`ifdef SB_STATS_EN
        return 32'(model_sc);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        //           rs iss il ret rl fl  a1  a2  dd  stall busy     err
        // 1: long write to $8 stalls a reader, retire releases it
        vecs.push_back(mk(0,  8, 1, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 0
        vecs.push_back(mk(0, -1, 0,  8, 1, 0,  8, -1, -1, 1'b1, 32'h100, 1'b0)); // 1
        vecs.push_back(mk(0, -1, 0, -1, 0, 0,  8, -1, -1, 1'b0, 32'h0,   1'b0)); // 2
        // 2: short write never stalls; dest 0 is ignored; source 0 never stalls
        vecs.push_back(mk(0,  9, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 3
        vecs.push_back(mk(0,  0, 1, -1, 0, 0, -1,  9, -1, 1'b0, 32'h200, 1'b0)); // 4
        vecs.push_back(mk(0, -1, 0,  9, 0, 0,  0,  9, -1, 1'b0, 32'h200, 1'b0)); // 5
        vecs.push_back(mk(0, -1, 0, -1, 0, 0,  0, -1,  0, 1'b0, 32'h0,   1'b0)); // 6
        // 3: same-cycle issue+retire of $5 leaves counts unchanged
        vecs.push_back(mk(0,  5, 1, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 7
        vecs.push_back(mk(0,  5, 1,  5, 1, 0,  5, -1, -1, 1'b1, 32'h20,  1'b0)); // 8
        vecs.push_back(mk(0, -1, 0,  5, 1, 0,  5, -1, -1, 1'b1, 32'h20,  1'b0)); // 9
        vecs.push_back(mk(0, -1, 0, -1, 0, 0,  5, -1, -1, 1'b0, 32'h0,   1'b0)); // 10
        // 4: $7 fills to 3, full-stall, 4th issue saturates and errors
        vecs.push_back(mk(0,  7, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 11
        vecs.push_back(mk(0,  7, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h80,  1'b0)); // 12
        vecs.push_back(mk(0,  7, 0, -1, 0, 0, -1, -1,  7, 1'b0, 32'h80,  1'b0)); // 13
        vecs.push_back(mk(0,  7, 0, -1, 0, 0, -1, -1,  7, 1'b1, 32'h80,  1'b0)); // 14
        vecs.push_back(mk(0, -1, 0,  7, 0, 0, -1, -1,  7, 1'b1, 32'h80,  1'b1)); // 15
        vecs.push_back(mk(0, -1, 0,  7, 0, 0, -1, -1,  7, 1'b0, 32'h80,  1'b1)); // 16
        vecs.push_back(mk(0, -1, 0,  7, 0, 0, -1, -1, -1, 1'b0, 32'h80,  1'b1)); // 17
        vecs.push_back(mk(0,  7, 1, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b1)); // 18
        // async reset mid-operation clears everything at once
        vecs.push_back(mk(1, -1, 0, -1, 0, 0,  7, -1, -1, 1'b0, 32'h0,   1'b0)); // 19
        vecs.push_back(mk(0, -1, 0, -1, 0, 0,  7, -1, -1, 1'b0, 32'h0,   1'b0)); // 20
        // 5: retire at zero errors; flush clears counters, keeps sb_err
        vecs.push_back(mk(0, -1, 0,  3, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 21
        vecs.push_back(mk(0,  3, 1, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b1)); // 22
        vecs.push_back(mk(0,  4, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h8,   1'b1)); // 23
        vecs.push_back(mk(0,  6, 1, -1, 0, 1,  3, -1, -1, 1'b1, 32'h18,  1'b1)); // 24
        vecs.push_back(mk(0, -1, 0, -1, 0, 0,  3, -1, -1, 1'b0, 32'h0,   1'b1)); // 25
        // long retire of a short write: cnt_long underflow errors
        vecs.push_back(mk(1, -1, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 26
        vecs.push_back(mk(0, 11, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b0)); // 27
        vecs.push_back(mk(0, -1, 0, 11, 1, 0, 11, -1, -1, 1'b0, 32'h800, 1'b0)); // 28
        vecs.push_back(mk(0, -1, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0,   1'b1)); // 29

        // Reset state
        drive(mk(1, -1, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0, 1'b0));
        #2;
        chk("rst_stall", -1, 32'(stall), 32'd0);
        chk("rst_busy",  -1, busy_vec,   32'd0);
        chk("rst_err",   -1, 32'(sb_err), 32'd0);
        chk("rst_scnt",  -1, stall_cnt,  32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            if (vecs[i].rs != 0) model_sc = 0;
            #1;
            chk("stall", i, 32'(stall),  32'(vecs[i].es));
            chk("busy",  i, busy_vec,    vecs[i].eb);
            chk("err",   i, 32'(sb_err), 32'(vecs[i].ee));
            chk("scnt",  i, stall_cnt,   exp_sc());
            if (vecs[i].es && vecs[i].rs == 0) model_sc++;
        end

        // 6: five stall cycles, then reset in the middle of the stall
        @(negedge clk);
        drive(mk(1, -1, 0, -1, 0, 0, -1, -1, -1, 1'b0, 32'h0, 1'b0));
        model_sc = 0;
        #1;
        @(negedge clk);
        // issue long $12 and an erroneous retire of idle $13 together
        drive(mk(0, 12, 1, 13, 0, 0, -1, -1, -1, 1'b0, 32'h0, 1'b0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(mk(0, -1, 0, -1, 0, 0, 12, -1, -1, 1'b0, 32'h0, 1'b0));
            #1;
            chk("h_stall", k, 32'(stall), 32'd1);
            chk("h_scnt",  k, stall_cnt,  exp_sc());
            model_sc++;
        end
        @(negedge clk);
        #1;
        chk("h_scnt5", 5, stall_cnt,   exp_sc());
        chk("h_busy",  5, busy_vec,    32'h1000);
        chk("h_err",   5, 32'(sb_err), 32'd1);
        rst = 1'b1;
        #1;
        chk("h_rst_stall", 6, 32'(stall),  32'd0);
        chk("h_rst_busy",  6, busy_vec,    32'd0);
        chk("h_rst_err",   6, 32'(sb_err), 32'd0);
        chk("h_rst_scnt",  6, stall_cnt,   32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
